seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Multi-cycle, width-parametrised successor of main_alu: same 3-bit opcode map, plus valid/ready handshakes.
//  Uses an iterative MUL/DIV engine instead of combinational * and /.
//  Sits between the operand issue stage and the writeback stage; holds one operation in flight.
// PARAMETERS
//  W    32   operand width in bits; must be >= 4.
//  SHW  $clog2(2*W)   localparam, shift-amount width (6 at W=32).
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst_n      in   1     synchronous, active-low reset
//  in_valid   in   1     operation offered
//  in_ready   out  1     engine accepts an operation this cycle
//  a          in   W     operand A
//  b          in   W     operand B
//  opcode     in   3     operation select (seq_alu_pkg::op_e)
//  shift      in   SHW   shift/rotate amount
//  out_valid  out  1     result held on out/carry
//  out_ready  in   1     consumer takes result
//  out        out  2W    result
//  carry      out  1     carry/borrow flag
//  err        out  1     only when SEQ_ALU_DIV0_FLAG_EN is defined
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; out, carry, err clear to 0; out_valid=0; in_ready=1.
//   - Reset aborts any in-flight op; the result is discarded.
//  Accept: operands, opcode and shift are captured when in_valid && in_ready. in_ready = (state==IDLE).
//  FSM states: IDLE -> EXEC (MUL/DIV only) -> DONE -> IDLE.
//   - Single-cycle ops go IDLE -> DONE directly: result is valid 1 cycle after accept.
//   - MUL/DIV spend W cycles in EXEC: out_valid is asserted W+1 cycles after accept.
//   - DONE: out_valid=1; out, carry and err are held stable until out_ready=1, then -> IDLE.
//   - No accept is possible while in DONE, even in the cycle out_ready=1.
//  Opcodes (unused upper bits of out are zero):
//   000 ADD: out[W-1:0]=a+b; carry=carry-out.
//   001 SUB: out[W-1:0]=a-b mod 2^W; carry=1 iff a<b (borrow).
//   010 MUL: out=a*b, unsigned, full 2W bits; shift-add, 1 bit/cycle; carry=0.
//   011 DIV: out={rem,quot}, unsigned; restoring division, 1 bit/cycle; carry=0.
//   100 SHL: out = {W'0,a} << shift (2W-bit, bits shifted past 2W lost); carry=0.
//   101 SHR: out[W-1:0] = a >> shift (logical); shift>=W gives 0; carry=0.
//   110 ROL: out[W-1:0] = a rotated left by (shift mod W); carry=0.
//   111 ROR: out[W-1:0] = a rotated right by (shift mod W); carry=0.
//  Operand b is ignored for opcodes 100-111.
//  DIV by zero: quot = all ones, rem = a; latency unchanged.
// CONFIGURATION
//  SEQ_ALU_DIV0_FLAG_EN:
//   - defined: port err exists; err=1 in DONE for DIV with b==0, else 0.
//   - undefined: no err port; DIV-by-zero result as above, no indication.
// STRUCTURE
//  seq_alu_pkg holds:
//   - op_e (3-bit opcode enum)
//   - state_e (IDLE/EXEC/DONE)
//   - OP_ADD..OP_ROR constants
//  Sub-module seq_alu_muldiv:
//   - iterative W-cycle engine: start/busy/done, {hi,lo} accumulator, is_div select.
//   - top level owns the handshake FSM and the single-cycle datapath.
// TESTING (W=32)
//  ADD 23+12 -> out=35, carry=0, out_valid 1 cycle after accept;
//   ADD FFFFFFFF+1 -> out=0, carry=1.
//  SUB 50-20 -> 30, carry=0; SUB 10-25 -> out[31:0]=FFFFFFF1, carry=1, out[63:32]=0.
//  MUL 7*6 -> 42 at W+1=33 cycles after accept;
//   MUL FFFFFFFF*FFFFFFFF -> FFFFFFFE_00000001.
//  DIV 103/10 -> out={32'd3,32'd10}; DIV 100/10 -> {0,10};
//   DIV 5/0 -> {5,FFFFFFFF} (err=1 if flag enabled).
//  SHL AAAAAAAA by 4 -> 0000000A_AAAAAAA0; ROR 12345678 by 8 -> 78123456;
//   SHR with shift=40 -> 0.
//  Backpressure: hold out_ready=0 for 5 cycles in DONE -> out stable, in_ready=0.
//  Reset: rst_n=0 at cycle 10 of a DIV -> next cycle state IDLE, out_valid=0, out=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode map, handshake FSM states and
// a helper that tells the top level which opcodes use the iterative engine.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_ROL = 3'b110,
        OP_ROR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // MUL and DIV run on the W-cycle engine; everything else finishes in one cycle.
    function automatic logic is_multicycle(op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply / divide engine, one result bit per cycle.
// A start pulse loads the operands; W iterations follow; {hi,lo} then holds
// a*b (multiply) or {remainder, quotient} (divide) until the next start.
// done is high in the cycle whose closing edge performs the last iteration.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  hi_q, lo_q, opnd_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, div_q;

    logic [W:0]    mul_sum, div_part, div_diff;
    logic          div_ge;
    logic [W-1:0]  hi_d, lo_d;

    // One iteration step: shift-add for multiply, restore-or-subtract for divide.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        hi_d     = hi_q;
        lo_d     = lo_q;
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_part = {hi_q, lo_q[W-1]};
        div_diff = div_part - {1'b0, opnd_q};
        div_ge   = (div_part >= {1'b0, opnd_q});
        if (div_q) begin
            // A zero divisor always compares ">=", so quotient bits are all ones
            // and the remainder ends up equal to the dividend.
            hi_d = div_ge ? div_diff[W-1:0] : div_part[W-1:0];
            lo_d = {lo_q[W-2:0], div_ge};
        end else begin
            hi_d = mul_sum[W:1];
            lo_d = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    assign done = busy_q && (cnt_q == CW'(W - 1));
    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Operand load on start, then one iteration per cycle while busy.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= a;
            opnd_q <= b;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            div_q  <= is_div;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides, one op in flight.
// Single-cycle ops: ADD SUB SHL SHR ROL ROR. MUL/DIV use seq_alu_muldiv.
// Optional feature macro: SEQ_ALU_DIV0_FLAG_EN adds the err port, which flags
// a DIV by zero while the result is presented.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter  int W   = 32,
    localparam int SHW = $clog2(2 * W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     opcode,
    input  logic [SHW-1:0] shift,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out,
    output logic           carry
`ifdef SEQ_ALU_DIV0_FLAG_EN
    ,
    output logic           err
`endif
);

    state_e         state_q, state_d;
    op_e            op;
    logic           accept, md_start, md_busy, md_done;
    logic [W-1:0]   md_hi, md_lo;

    logic [W:0]     add_full, sub_full;
    logic [SHW-1:0] rot_amt;
    logic [2*W-1:0] rot_pair_l, rot_pair_r;
    logic [2*W-1:0] sc_res, res_q;
    logic           sc_carry, carry_q, md_sel_q;
`ifdef SEQ_ALU_DIV0_FLAG_EN
    logic           err_q;
`endif

    assign op = op_e'(opcode);

    seq_alu_muldiv #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    // Single-cycle datapath, evaluated on the live operands at accept time.
    always_comb begin
        add_full   = {1'b0, a} + {1'b0, b};
        sub_full   = {1'b0, a} - {1'b0, b};
        rot_amt    = SHW'(int'(shift) % W);
        rot_pair_l = {a, a} << rot_amt;
        rot_pair_r = {a, a} >> rot_amt;
        sc_res     = '0;
        sc_carry   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res[W-1:0] = add_full[W-1:0];
                sc_carry      = add_full[W];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (a < b).
                sc_res[W-1:0] = sub_full[W-1:0];
                sc_carry      = sub_full[W];
            end
            OP_SHL:  sc_res        = {{W{1'b0}}, a} << shift;
            OP_SHR:  sc_res[W-1:0] = a >> shift;
            OP_ROL:  sc_res[W-1:0] = rot_pair_l[2*W-1:W];
            OP_ROR:  sc_res[W-1:0] = rot_pair_r[W-1:0];
            default: sc_res        = '0;
        endcase
    end

    // Handshake FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        md_start  = 1'b0;
        case (state_q)
            IDLE: begin
                // The engine is never busy in IDLE; the gate keeps a stray
                // start from ever overlapping a running iteration.
                in_ready = !md_busy;
                if (in_valid && !md_busy) begin
                    accept = 1'b1;
                    if (is_multicycle(op)) begin
                        md_start = 1'b1;
                        state_d  = EXEC;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            EXEC: begin
                if (md_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result capture at accept; held untouched through EXEC and DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q    <= '0;
            carry_q  <= 1'b0;
            md_sel_q <= 1'b0;
`ifdef SEQ_ALU_DIV0_FLAG_EN
            err_q    <= 1'b0;
`endif
        end else if (accept) begin
            res_q    <= sc_res;
            carry_q  <= sc_carry;
            md_sel_q <= is_multicycle(op);
`ifdef SEQ_ALU_DIV0_FLAG_EN
            err_q    <= (op == OP_DIV) && (b == '0);
`endif
        end
    end

    // MUL/DIV results are read straight from the engine accumulator, which
    // stays frozen once the last iteration has run.
    assign out   = md_sel_q ? {md_hi, md_lo} : res_q;
    assign carry = carry_q;
`ifdef SEQ_ALU_DIV0_FLAG_EN
    assign err   = err_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at W=32: the driver pushes model results into
// a queue at accept, an independent monitor compares whenever out_valid is up.
module tb_seq_alu;

    localparam int W   = 32;
    localparam int SHW = $clog2(2 * W);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2:0]     opcode = '0;
    logic [SHW-1:0] shift = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out;
    logic           carry;
`ifdef SEQ_ALU_DIV0_FLAG_EN
    logic           err;
`endif

    seq_alu #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry     (carry)
`ifdef SEQ_ALU_DIV0_FLAG_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] out;
        logic        carry;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   lat_checked = 0;
    bit   bp_hold = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: random backpressure, forced low while bp_hold is set.
    always @(posedge clk) begin
        #2;
        out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the opcode table, using wide arithmetic.
    function automatic exp_t model(logic [2:0] op, logic [31:0] x, logic [31:0] y, logic [5:0] sh);
        exp_t        e;
        logic [63:0] s;
        logic [31:0] r;
        e.out = '0; e.carry = 1'b0; e.err = 1'b0; e.lat = 1; e.acc_cyc = 0;
        r = x;
        case (op)
            3'd0: begin s = 64'(x) + 64'(y); e.out = {32'b0, s[31:0]}; e.carry = s[32]; end
            3'd1: begin s = 64'(x) - 64'(y); e.out = {32'b0, s[31:0]}; e.carry = (x < y); end
            3'd2: begin e.out = 64'(x) * 64'(y); e.lat = W + 1; end
            3'd3: begin
                e.lat = W + 1;
                if (y == 0) begin e.out = {x, 32'hFFFF_FFFF}; e.err = 1'b1; end
                else e.out = {x % y, x / y};
            end
            3'd4: e.out = 64'(x) << sh;
            3'd5: e.out = (sh >= 32) ? 64'd0 : 64'(x >> sh);
            3'd6: begin
                for (int i = 0; i < int'(sh) % 32; i++) r = {r[30:0], r[31]};
                e.out = 64'(r);
            end
            default: begin
                for (int i = 0; i < int'(sh) % 32; i++) r = {r[0], r[31:1]};
                e.out = 64'(r);
            end
        endcase
        return e;
    endfunction

    // Offer one op, wait (bounded) for acceptance, record the expected result.
    task automatic issue(logic [2:0] op, logic [31:0] x, logic [31:0] y, logic [5:0] sh);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = x; b = y; shift = sh;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready=%b, want 1 within 500 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        e = model(op, x, y, sh);
        e.acc_cyc = cyc;
        @(posedge clk);
        exp_q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
            lat_checked = 0;
        end
    endtask

    // Monitor: compares the presented result against the queue head every
    // cycle it is shown (so backpressure stability is covered), pops on take.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_result: out_valid=1 with none outstanding, out=%h", out);
            end else begin
                mon_e = exp_q[0];
                if (!lat_checked) begin
                    check("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
                    lat_checked = 1;
                end
                check("out", out, mon_e.out);
                check("carry", 64'(carry), 64'(mon_e.carry));
`ifdef SEQ_ALU_DIV0_FLAG_EN
                check("err", 64'(err), 64'(mon_e.err));
`endif
                check("in_ready_while_done", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    lat_checked = 0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out", out, 64'd0);
        check("reset_carry", 64'(carry), 64'd0);
        rst_n = 1'b1;

        // Directed vectors, including the boundary cases.
        issue(3'd0, 32'd23, 32'd12, 6'd0);
        issue(3'd0, 32'hFFFF_FFFF, 32'd1, 6'd0);
        issue(3'd1, 32'd50, 32'd20, 6'd0);
        issue(3'd1, 32'd10, 32'd25, 6'd0);
        issue(3'd2, 32'd7, 32'd6, 6'd0);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0);
        issue(3'd3, 32'd103, 32'd10, 6'd0);
        issue(3'd3, 32'd100, 32'd10, 6'd0);
        issue(3'd3, 32'd5, 32'd0, 6'd0);
        issue(3'd4, 32'hAAAA_AAAA, 32'd0, 6'd4);
        issue(3'd4, 32'hFFFF_FFFF, 32'd0, 6'd63);
        issue(3'd7, 32'h1234_5678, 32'd0, 6'd8);
        issue(3'd6, 32'h8000_0001, 32'd9, 6'd33);
        issue(3'd5, 32'hFFFF_FFFF, 32'd0, 6'd40);
        issue(3'd5, 32'h8000_0000, 32'd0, 6'd31);
        drain();

        // Backpressure: result must hold while out_ready stays low.
        bp_hold = 1;
        issue(3'd0, 32'h1357_9BDF, 32'h0246_8ACE, 6'd0);
        repeat (6) @(negedge clk);
        bp_hold = 0;
        drain();

        // Randomised traffic with a bias toward edge operands.
        for (int i = 0; i < 150; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) r_b = r_b >> $urandom_range(0, 31);
            issue(r_op, r_a, r_b, 6'($urandom_range(0, 63)));
        end
        drain();

        // Reset in the middle of a DIV discards it.
        issue(3'd3, 32'd103, 32'd10, 6'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        lat_checked = 0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out", out, 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        issue(3'd0, 32'd23, 32'd12, 6'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
